mem_port_arbiter: RTL and testbench

- Shares the single CPU RAM port between instruction fetch (IF) and the memory stage (DM).
- Sequences each access through the RAM's fixed read latency and returns read data with a one-cycle done pulse.
- Requesters stall their pipeline stage while their request is outstanding.
- Sits between the fetch/memory pipeline stages and the RAM.

---
 rtl/cpu_mem_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU RAM port arbiter: FSM states, port IDs,
// latency bounds and the access-length helper.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_id_e;

  localparam int unsigned MAX_RAM_LATENCY = 4;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned CNT_W           = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  // Writes retire after one RAM cycle; reads wait out the full RAM latency.
  function automatic cnt_t access_len(input logic we, input int unsigned lat);
    return we ? cnt_t'(1) : cnt_t'(lat);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational IF/DM grant picker. Optional MEM_ARB_ROUND_ROBIN_EN makes
// ties alternate on the previous grant; otherwise DM has fixed priority.
module mem_arb_pick
  import cpu_mem_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_dm,
  output logic valid
);

  always_comb begin
    valid = if_req | dm_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (if_req && dm_req) begin
      grant_dm = (last_grant == logic'(PORT_IF));
    end else begin
      grant_dm = dm_req;
    end
`else
    grant_dm = dm_req;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and the memory stage, with
// registered outputs and per-port done pulses. Macro: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_dm
);

  if (RAM_LATENCY < 1 || RAM_LATENCY > MAX_RAM_LATENCY) begin : g_bad_latency
    $error("mem_port_arbiter: RAM_LATENCY must be in 1..4");
  end

  arb_state_e        r_state;
  cnt_t              r_cnt;
  logic              r_is_wr;
  logic              r_grant_dm;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_done;
  logic              r_dm_done;
  logic              r_busy;

  logic w_grant_dm;
  logic w_valid;
  logic w_win_we;

  // The grant_dm register already records the previous winner, so it
  // doubles as the round-robin history.
  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant (r_grant_dm),
`endif
    .grant_dm   (w_grant_dm),
    .valid      (w_valid)
  );

  assign w_win_we = w_grant_dm & dm_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_wr     <= 1'b0;
      r_grant_dm  <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      r_ram_we  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_grant_dm  <= w_grant_dm;
            r_ram_addr  <= w_grant_dm ? dm_addr : if_addr;
            r_ram_wdata <= w_grant_dm ? dm_wdata : '0;
            r_ram_we    <= w_win_we;
            r_is_wr     <= w_win_we;
            r_cnt       <= access_len(w_win_we, RAM_LATENCY);
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt - cnt_t'(1);
          if (r_cnt == cnt_t'(1)) begin
            if (!r_is_wr) begin
              if (r_grant_dm) r_dm_rdata <= ram_rdata;
              else            r_if_rdata <= ram_rdata;
            end
            if (r_grant_dm) r_dm_done <= 1'b1;
            else            r_if_done <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_done   = r_if_done;
  assign dm_rdata  = r_dm_rdata;
  assign dm_done   = r_dm_done;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign busy      = r_busy;
  assign grant_dm  = r_grant_dm;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus random
// two-port traffic against a transaction-level timeline model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        busy;
  logic        grant_dm;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .RAM_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .grant_dm  (grant_dm)
  );

  function automatic int unsigned idx(input logic [31:0] a);
    return {24'd0, a[9:2]};
  endfunction

  function automatic logic [31:0] init_val(input int unsigned i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_0101);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM: writes on the edge, reads through LAT-1 register stages.
  logic [31:0] ram_mem [256];
  bit          ram_wr  [256];
  logic [31:0] rd_pipe [3];

  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[idx(ram_addr)] <= ram_wdata;
      ram_wr[idx(ram_addr)]  <= 1'b1;
    end
    rd_pipe[0] <= ram_wr[idx(ram_addr)] ? ram_mem[idx(ram_addr)] : init_val(idx(ram_addr));
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign ram_rdata = rd_pipe[LAT-2];

  // Reference model: an access granted at edge t retires its write at t+1,
  // raises done for cycle t+lat+1 and frees the port at t+lat+2.
  int          m_rem = 0;
  bit          m_dm, m_we, m_busy, m_ram_we, m_if_done, m_dm_done, m_win;
  bit   [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
  logic [31:0] m_mem [256];
  bit          m_wr  [256];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_rem = 0; m_dm = 0; m_we = 0; m_busy = 0; m_ram_we = 0;
      m_if_done = 0; m_dm_done = 0; m_addr = 0; m_wdata = 0;
      m_if_rd = 0; m_dm_rd = 0;
    end else begin
      m_if_done = 0; m_dm_done = 0; m_ram_we = 0;
      if (m_rem == 0) begin
        if (if_req || dm_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          m_win = (if_req && dm_req) ? !m_dm : dm_req;
`else
          m_win = dm_req;
`endif
          m_dm     = m_win;
          m_we     = m_win && dm_we;
          m_addr   = m_win ? dm_addr : if_addr;
          m_wdata  = m_win ? dm_wdata : 32'd0;
          m_ram_we = m_we;
          m_busy   = 1;
          m_rem    = (m_we ? 1 : int'(LAT)) + 1;
        end
      end else begin
        m_rem--;
        if (m_rem == 1) begin
          if (m_we) begin
            m_mem[idx(m_addr)] = m_wdata;
            m_wr[idx(m_addr)]  = 1;
          end else if (m_dm) begin
            m_dm_rd = m_wr[idx(m_addr)] ? m_mem[idx(m_addr)] : init_val(idx(m_addr));
          end else begin
            m_if_rd = m_wr[idx(m_addr)] ? m_mem[idx(m_addr)] : init_val(idx(m_addr));
          end
          if (m_dm) m_dm_done = 1;
          else      m_if_done = 1;
        end else if (m_rem == 0) begin
          m_busy = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en && !rst) begin
      check("busy",      busy,      m_busy);
      check("grant_dm",  grant_dm,  m_dm);
      check("ram_we",    ram_we,    m_ram_we);
      check("ram_addr",  ram_addr,  m_addr);
      check("ram_wdata", ram_wdata, m_wdata);
      check("if_done",   if_done,   m_if_done);
      check("dm_done",   dm_done,   m_dm_done);
      check("if_rdata",  if_rdata,  m_if_rd);
      check("dm_rdata",  dm_rdata,  m_dm_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one access from IDLE and counts cycles until its done pulse.
  task automatic xfer(input bit to_dm, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, output int n, output int we_cyc,
                      output logic [31:0] we_addr, output logic [31:0] we_data);
    if (to_dm) begin
      dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr;
    end
    n = 0; we_cyc = 0; we_addr = '0; we_data = '0;
    do begin
      tick();
      n++;
      if (ram_we) begin
        we_cyc++; we_addr = ram_addr; we_data = ram_wdata;
      end
    end while (!(to_dm ? dm_done : if_done) && n < 20);
    dm_req = 0; if_req = 0;
    tick();
  endtask

  int          n, wc, pulses, idles, n_if, n_dm, first, w;
  logic [31:0] wa, wd;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("reset busy",     busy,      0);
    check("reset grant_dm", grant_dm,  0);
    check("reset ram_we",   ram_we,    0);
    check("reset ram_addr", ram_addr,  0);
    check("reset dones",    {if_done, dm_done}, 0);
    check("reset rdata",    {if_rdata, dm_rdata}, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    xfer(1, 1, 32'h100, 32'hDEAD_BEEF, n, wc, wa, wd);
    check("store0 latency", n, 2);
    check("store0 we cycles", wc, 1);
    check("store0 we addr", wa, 32'h100);

    xfer(1, 0, 32'h100, 32'h0, n, wc, wa, wd);
    check("load latency", n, LAT + 1);
    check("load we cycles", wc, 0);
    check("load ram_addr", ram_addr, 32'h100);
    check("load dm_rdata", dm_rdata, 32'hDEAD_BEEF);

    xfer(1, 1, 32'h40, 32'h1234_5678, n, wc, wa, wd);
    check("store latency", n, 2);
    check("store we cycles", wc, 1);
    check("store we addr", wa, 32'h40);
    check("store we data", wd, 32'h1234_5678);
    check("store keeps dm_rdata", dm_rdata, 32'hDEAD_BEEF);

    if_req = 1; if_addr = 32'h0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    pulses = 0; n_if = 0; n_dm = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (dm_done) begin pulses++; n_dm = c; dm_req = 0; end
      if (if_done) begin pulses++; n_if = c; if_req = 0; end
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("contend if cycle", n_if, LAT + 1);
    check("contend dm cycle", n_dm, 2 * LAT + 3);
`else
    check("contend dm cycle", n_dm, LAT + 1);
    check("contend if cycle", n_if, 2 * LAT + 3);
`endif
    check("contend pulses", pulses, 2);
    check("contend if_rdata", if_rdata, init_val(0));
    check("contend dm_rdata", dm_rdata, init_val(128));

    if_req = 1; if_addr = 32'h44;
    pulses = 0; idles = 0; first = 0;
    for (int c = 1; c <= 3 * (LAT + 2); c++) begin
      tick();
      if (if_done) begin pulses++; if (first == 0) first = c; end
      if (!busy) idles++;
    end
    if_req = 0;
    check("held first done", first, LAT + 1);
    check("held pulses", pulses, 3);
    check("held idle cycles", idles, 3);
    w = 0;
    while (busy && w < 20) begin tick(); w++; end
    check("held drain", busy, 0);
    tick();

    dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hAAAA_5555;
    tick();
    check("rst-mid ram_we before", ram_we, 1);
    #2 rst = 1'b1;
    dm_req = 0;
    #1;
    check("rst-mid ram_we", ram_we, 0);
    check("rst-mid busy", busy, 0);
    check("rst-mid ram_addr", ram_addr, 0);
    check("rst-mid dm_rdata", dm_rdata, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dm_done) pulses++;
    end
    check("rst-mid no dm_done", pulses, 0);
    xfer(0, 0, 32'h80, 32'h0, n, wc, wa, wd);
    check("post-rst if latency", n, LAT + 1);
    check("post-rst if_rdata", if_rdata, init_val(32));

    for (int c = 0; c < 600; c++) begin
      tick();
      if (if_req) begin
        if (if_done) begin
          if_req = ($urandom_range(0, 1) == 1);
          if_addr = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_req) begin
        if (dm_done) begin
          dm_req = ($urandom_range(0, 1) == 1);
          dm_we = ($urandom_range(0, 1) == 1);
          dm_addr = $urandom; dm_wdata = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = ($urandom_range(0, 1) == 1);
        dm_addr = $urandom; dm_wdata = $urandom;
      end
    end
    if_req = 0; dm_req = 0;
    w = 0;
    while (busy && w < 20) begin tick(); w++; end
    check("final drain", busy, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
